// File: rtl/sw_mem_arbiter_if.sv
// Bundle of the T/Q burst requester ports and the SRAM read port around sw_mem_arbiter.
`ifndef SRAM_ADDR_BIT
`define SRAM_ADDR_BIT 8
`endif
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 16
`endif

interface sw_mem_arbiter_if #(
    parameter int ADDR_W = `SRAM_ADDR_BIT,
    parameter int WORD_W = `SRAM_WORD_WIDTH,
    parameter int LEN_W  = 8
);
    logic              t_req_i;
    logic [ADDR_W-1:0] t_addr_i;
    logic [LEN_W-1:0]  t_len_i;
    logic              t_ack_o;
    logic              t_valid_o;
    logic              t_last_o;
    logic [WORD_W-1:0] t_data_o;

    logic              q_req_i;
    logic [ADDR_W-1:0] q_addr_i;
    logic [LEN_W-1:0]  q_len_i;
    logic              q_ack_o;
    logic              q_valid_o;
    logic              q_last_o;
    logic [WORD_W-1:0] q_data_o;

    logic              sram_en_o;
    logic              sram_sel_T_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [WORD_W-1:0] sram_data_i;
    logic              busy_o;

    modport slave (
        input  t_req_i, t_addr_i, t_len_i, q_req_i, q_addr_i, q_len_i, sram_data_i,
        output t_ack_o, t_valid_o, t_last_o, t_data_o,
               q_ack_o, q_valid_o, q_last_o, q_data_o,
               sram_en_o, sram_sel_T_o, sram_addr_o, busy_o
    );

    modport master (
        output t_req_i, t_addr_i, t_len_i, q_req_i, q_addr_i, q_len_i, sram_data_i,
        input  t_ack_o, t_valid_o, t_last_o, t_data_o,
               q_ack_o, q_valid_o, q_last_o, q_data_o,
               sram_en_o, sram_sel_T_o, sram_addr_o, busy_o
    );
endinterface

// File: rtl/sw_mem_arbiter.sv
// Round-robin, per-burst arbiter sharing one SRAM read port between the T and Q loaders.
`ifndef SRAM_ADDR_BIT
`define SRAM_ADDR_BIT 8
`endif
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 16
`endif

module sw_mem_arbiter #(
    parameter int ADDR_W = `SRAM_ADDR_BIT,
    parameter int WORD_W = `SRAM_WORD_WIDTH,
    parameter int LEN_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    sw_mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              own_t_q, own_t_d;
    logic              last_t_q, last_t_d;
    logic              vld_q, lst_q, ret_t_q;

    logic gnt_t, gnt_q, issue, issue_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            own_t_q  <= 1'b0;
            last_t_q <= 1'b0;
            vld_q    <= 1'b0;
            lst_q    <= 1'b0;
            ret_t_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            own_t_q  <= own_t_d;
            last_t_q <= last_t_d;
            vld_q    <= issue;
            lst_q    <= issue_last;
            ret_t_q  <= own_t_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        own_t_d    = own_t_q;
        last_t_d   = last_t_q;
        gnt_t      = 1'b0;
        gnt_q      = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            IDLE: begin
                // On contention the requester not granted last time wins.
                if (bus.t_req_i && (!bus.q_req_i || !last_t_q)) gnt_t = 1'b1;
                else if (bus.q_req_i)                            gnt_q = 1'b1;
                if (gnt_t || gnt_q) begin
                    state_d  = BURST;
                    base_d   = gnt_t ? bus.t_addr_i : bus.q_addr_i;
                    len_d    = gnt_t ? bus.t_len_i  : bus.q_len_i;
                    own_t_d  = gnt_t;
                    last_t_d = gnt_t;
                    cnt_d    = '0;
                end
            end
            BURST: begin
                issue      = (len_q != '0);
                issue_last = issue && (cnt_q == len_q - 1'b1);
                cnt_d      = cnt_q + 1'b1;
                if (!issue || issue_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is combinational from IDLE, so it must be masked while reset is held.
    assign bus.t_ack_o      = gnt_t & ~rst;
    assign bus.q_ack_o      = gnt_q & ~rst;
    assign bus.sram_en_o    = issue;
    assign bus.sram_sel_T_o = issue & own_t_q;
    assign bus.sram_addr_o  = issue ? base_q + ADDR_W'(cnt_q) : '0;

    assign bus.t_valid_o = vld_q & ret_t_q;
    assign bus.t_last_o  = lst_q & ret_t_q;
    assign bus.t_data_o  = bus.t_valid_o ? bus.sram_data_i : '0;
    assign bus.q_valid_o = vld_q & ~ret_t_q;
    assign bus.q_last_o  = lst_q & ~ret_t_q;
    assign bus.q_data_o  = bus.q_valid_o ? bus.sram_data_i : '0;
    assign bus.busy_o    = (state_q == BURST) | vld_q;
endmodule

// File: tb/tb_sw_mem_arbiter.sv
// Scoreboard bench for sw_mem_arbiter: stimulus queues expected acks, SRAM reads and returns.
module tb_sw_mem_arbiter;
  localparam int AW = 8;
  localparam int WW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sw_mem_arbiter_if #(.ADDR_W(AW), .WORD_W(WW), .LEN_W(LW)) bus ();
  sw_mem_arbiter #(.ADDR_W(AW), .WORD_W(WW), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [WW-1:0] mem_f(input logic sel, input logic [AW-1:0] a);
    return {a, ~a} ^ (sel ? 16'hA500 : 16'h005A);
  endfunction

  // SRAM model: data for an issued read appears the following cycle.
  always @(posedge clk)
    bus.sram_data_i <= bus.sram_en_o ? mem_f(bus.sram_sel_T_o, bus.sram_addr_o) : '0;

  typedef struct {
    logic          is_t;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          last;
    int            off;
  } exp_t;

  exp_t ack_q[$];
  exp_t sram_q[$];
  exp_t ret_q[$];

  int checks = 0, failures = 0;
  int timeouts = 0;
  int cyc = 0, base_cyc = 0, last_ack = -100;
  logic fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [48:0] outs;
  assign outs = {bus.t_ack_o, bus.t_valid_o, bus.t_last_o, bus.t_data_o,
                 bus.q_ack_o, bus.q_valid_o, bus.q_last_o, bus.q_data_o,
                 bus.sram_en_o, bus.sram_sel_T_o, bus.sram_addr_o, bus.busy_o};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: returns are processed before acks so a last word sharing a cycle
  // with the next ack is timed against its own burst.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("reset_outputs_zero", 64'(outs), 64'd0);
    end else begin
      if (bus.t_valid_o || bus.q_valid_o) begin
        if (ret_q.size() == 0) chk("unexpected_valid", {62'd0, bus.t_valid_o, bus.q_valid_o}, 64'd0);
        else begin
          e = ret_q.pop_front();
          chk("ret_owner", {62'd0, bus.t_valid_o, bus.q_valid_o}, e.is_t ? 64'd2 : 64'd1);
          chk("ret_data", 64'(bus.t_valid_o ? bus.t_data_o : bus.q_data_o), 64'(e.data));
          chk("ret_last", {62'd0, bus.t_last_o, bus.q_last_o},
              e.last ? (e.is_t ? 64'd2 : 64'd1) : 64'd0);
          chk("ret_cycle", 64'(cyc - base_cyc), 64'(e.off));
        end
      end else begin
        chk("idle_ret_zero", 64'({bus.t_last_o, bus.t_data_o, bus.q_last_o, bus.q_data_o}), 64'd0);
      end

      if (bus.sram_en_o) begin
        if (sram_q.size() == 0) chk("unexpected_sram_en", 64'(bus.sram_en_o), 64'd0);
        else begin
          e = sram_q.pop_front();
          chk("sram_sel_T", 64'(bus.sram_sel_T_o), 64'(e.is_t));
          chk("sram_addr", 64'(bus.sram_addr_o), 64'(e.addr));
          chk("sram_cycle", 64'(cyc - base_cyc), 64'(e.off));
        end
      end else begin
        chk("idle_sram_zero", 64'({bus.sram_sel_T_o, bus.sram_addr_o}), 64'd0);
      end

      if (bus.t_ack_o || bus.q_ack_o) begin
        if (ack_q.size() == 0) chk("unexpected_ack", {62'd0, bus.t_ack_o, bus.q_ack_o}, 64'd0);
        else begin
          e = ack_q.pop_front();
          chk("ack_owner", {62'd0, bus.t_ack_o, bus.q_ack_o}, e.is_t ? 64'd2 : 64'd1);
          if (e.off >= 0) chk("ack_gap", 64'(cyc - last_ack), 64'(e.off));
        end
        base_cyc = cyc;
        last_ack = cyc;
      end
    end

    if (fin) begin
      chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
      chk("sram_queue_drained", 64'(sram_q.size()), 64'd0);
      chk("ret_queue_drained", 64'(ret_q.size()), 64'd0);
      chk("wait_timeouts", 64'(timeouts), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic push_burst(input logic is_t, input logic [AW-1:0] a, input int len, input int gap);
    exp_t e;
    logic [AW-1:0] ak;
    e.is_t = is_t; e.addr = a; e.data = '0; e.last = 1'b0; e.off = gap;
    ack_q.push_back(e);
    for (int k = 0; k < len; k++) begin
      ak = a + AW'(k);
      e.addr = ak; e.data = '0; e.last = 1'b0; e.off = k + 1;
      sram_q.push_back(e);
      e.data = mem_f(is_t, ak); e.last = (k == len - 1); e.off = k + 2;
      ret_q.push_back(e);
    end
  endtask

  task automatic req(input logic is_t, input logic [AW-1:0] a, input logic [LW-1:0] len);
    logic got;
    got = 1'b0;
    if (is_t) begin bus.t_req_i = 1'b1; bus.t_addr_i = a; bus.t_len_i = len; end
    else      begin bus.q_req_i = 1'b1; bus.q_addr_i = a; bus.q_len_i = len; end
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = is_t ? bus.t_ack_o : bus.q_ack_o;
    end
    if (!got) timeouts++;
    @(posedge clk); #1;
    // Scramble fields after ack; the arbiter must have latched them already.
    if (is_t) begin bus.t_req_i = 1'b0; bus.t_addr_i = ~a; bus.t_len_i = 8'd7; end
    else      begin bus.q_req_i = 1'b0; bus.q_addr_i = ~a; bus.q_len_i = 8'd7; end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = !bus.busy_o && ack_q.size() == 0 && sram_q.size() == 0 && ret_q.size() == 0;
    end
    if (!done) timeouts++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst = 1'b1;
    bus.t_req_i = 1'b0; bus.t_addr_i = '0; bus.t_len_i = '0;
    bus.q_req_i = 1'b0; bus.q_addr_i = '0; bus.q_len_i = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single T burst: addresses 5,6,7.
    push_burst(1'b1, 8'd5, 3, -1);
    req(1'b1, 8'd5, 8'd3);
    drain();

    // Reset restores T priority; Q follows exactly 3 cycles after T.
    pulse_reset();
    push_burst(1'b1, 8'd0, 2, -1);
    push_burst(1'b0, 8'd10, 2, 3);
    fork
      req(1'b1, 8'd0, 8'd2);
      req(1'b0, 8'd10, 8'd2);
    join
    drain();

    // Fairness: both held, len 1 -> T,Q,T,Q every 2 cycles.
    push_burst(1'b1, 8'd100, 1, -1);
    push_burst(1'b0, 8'd200, 1, 2);
    push_burst(1'b1, 8'd100, 1, 2);
    push_burst(1'b0, 8'd200, 1, 2);
    bus.t_addr_i = 8'd100; bus.t_len_i = 8'd1; bus.t_req_i = 1'b1;
    bus.q_addr_i = 8'd200; bus.q_len_i = 8'd1; bus.q_req_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (bus.t_ack_o || bus.q_ack_o) acks++;
    end
    if (acks < 4) timeouts++;
    @(posedge clk); #1;
    bus.t_req_i = 1'b0; bus.q_req_i = 1'b0;
    drain();

    // Address wrap: 254,255,0,1.
    push_burst(1'b0, 8'd254, 4, -1);
    req(1'b0, 8'd254, 8'd4);
    drain();

    // Zero-length T burst, then contention goes to Q.
    push_burst(1'b1, 8'd7, 0, -1);
    push_burst(1'b0, 8'd40, 1, 2);
    push_burst(1'b1, 8'd30, 1, 2);
    req(1'b1, 8'd7, 8'd0);
    fork
      req(1'b1, 8'd30, 8'd1);
      req(1'b0, 8'd40, 8'd1);
    join
    drain();

    // Reset at issue of word k=1 of a len-5 T burst: only word 0 is ever issued.
    push_burst(1'b1, 8'd20, 1, -1);
    void'(ret_q.pop_back());
    req(1'b1, 8'd20, 8'd5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push_burst(1'b1, 8'd50, 2, -1);
    push_burst(1'b0, 8'd60, 1, 3);
    fork
      req(1'b1, 8'd50, 8'd2);
      req(1'b0, 8'd60, 8'd1);
    join
    drain();

    fin = 1'b1;
  end
endmodule
